zion_rsn_skid_dff: RTL and testbench

//   Two-entry registered pipeline slice with a valid/ready handshake on both sides.
//   It is the backpressure-aware counterpart of the plain reset DFF stage.
//   The downstream end can stall via out_rdy without any data being dropped or duplicated.

---
 rtl/zion_rsn_skid_dff.sv | 105 ++++++++++
 tb/tb_zion_rsn_skid_dff.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/zion_rsn_skid_dff.sv
// Two-entry registered valid/ready pipeline slice. The downstream side can stall
// without losing beats, and in_rdy/out_vld/occ come straight from flops.
module zion_rsn_skid_dff #(
  parameter int               WIDTH    = 8,
  parameter logic [WIDTH-1:0] INI_DATA = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [WIDTH-1:0] in_dat,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [WIDTH-1:0] out_dat,
  output logic [1:0]       occ
);

  if (WIDTH < 1) begin : g_width_check
    $error("zion_rsn_skid_dff: WIDTH must be >= 1");
  end

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] skid;
  logic [WIDTH-1:0] skid_nxt;
  logic [WIDTH-1:0] dat_nxt;
  logic             acc;
  logic             take;

  assign acc  = in_vld & in_rdy;
  assign take = out_vld & out_rdy;

  // Next-state and next-data selection; a flush overrides any handshake.
  always_comb begin
    state_nxt = state;
    dat_nxt   = out_dat;
    skid_nxt  = skid;
    if (clr) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (acc) begin
            state_nxt = ONE;
            dat_nxt   = in_dat;
          end else begin
            state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (acc && take) begin
            state_nxt = ONE;
            dat_nxt   = in_dat;
          end else if (acc) begin
            state_nxt = TWO;
            skid_nxt  = in_dat;
          end else if (take) begin
            state_nxt = EMPTY;
          end else begin
            state_nxt = ONE;
          end
        end
        TWO: begin
          // in_rdy is low here, so only the drain of the head beat can happen.
          if (take) begin
            state_nxt = ONE;
            dat_nxt   = skid;
          end else begin
            state_nxt = TWO;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // State, payload and handshake flops; status outputs are registered copies of the next state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= EMPTY;
      out_dat <= INI_DATA;
      skid    <= INI_DATA;
      out_vld <= 1'b0;
      in_rdy  <= 1'b0;
      occ     <= 2'd0;
    end else begin
      state   <= state_nxt;
      out_dat <= dat_nxt;
      skid    <= skid_nxt;
      out_vld <= (state_nxt != EMPTY);
      in_rdy  <= (state_nxt != TWO);
      occ     <= state_nxt;
    end
  end

endmodule

// File: tb/tb_zion_rsn_skid_dff.sv
// Self-checking bench for zion_rsn_skid_dff: directed scenarios plus a random
// stall/stream run, with a negedge scoreboard checking order, loss and duplication.
module tb_zion_rsn_skid_dff;
  localparam int          W   = 32;
  localparam logic [W-1:0] INI = 32'hC0DE_5A5A;

  logic         clk = 1'b0;
  logic         rst;
  logic         clr;
  logic         in_vld;
  logic         in_rdy;
  logic [W-1:0] in_dat;
  logic         out_vld;
  logic         out_rdy;
  logic [W-1:0] out_dat;
  logic [1:0]   occ;

  int           total = 0;
  int           bad   = 0;
  int           nout  = 0;
  logic [W-1:0] sb[$];
  logic         stall_p = 1'b0;
  logic [W-1:0] dat_p   = '0;

  zion_rsn_skid_dff #(.WIDTH(W), .INI_DATA(INI)) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_dat(in_dat),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_dat(out_dat),
    .occ(occ)
  );

  always #5 clk = ~clk;

  // Scoreboard and stall-stability monitor; samples on the negedge before each transfer edge.
  initial begin
    logic [W-1:0] exp;
    forever begin
      @(negedge clk);
      if (stall_p && rst) begin
        total++;
        if (out_vld !== 1'b1 || out_dat !== dat_p) begin
          bad++;
          $display("FAIL stall_hold: out_vld=%b out_dat=%h required out_vld=1 out_dat=%h", out_vld, out_dat, dat_p);
        end
      end
      stall_p = rst && !clr && out_vld && !out_rdy;
      dat_p   = out_dat;
      if (!rst || clr) begin
        sb.delete();
      end else begin
        if (out_vld && out_rdy) begin
          total++;
          nout++;
          if (sb.size() == 0) begin
            bad++;
            $display("FAIL sb_extra: out_dat=%h emitted, required no beat", out_dat);
          end else begin
            exp = sb.pop_front();
            if (out_dat !== exp) begin
              bad++;
              $display("FAIL sb_order: out_dat=%h required %h", out_dat, exp);
            end
          end
        end
        if (in_vld && in_rdy) sb.push_back(in_dat);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; clr = 1'b0; in_vld = 1'b1; in_dat = 32'h11; out_rdy = 1'b0;
    repeat (2) step();
    total++; if (out_vld !== 1'b0) begin bad++; $display("FAIL rst_out_vld: got %b required 0", out_vld); end
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL rst_in_rdy: got %b required 0", in_rdy); end
    total++; if (occ !== 2'd0) begin bad++; $display("FAIL rst_occ: got %0d required 0", occ); end
    total++; if (out_dat !== INI) begin bad++; $display("FAIL rst_out_dat: got %h required %h", out_dat, INI); end
    rst = 1'b1;
    #1;
    total++; if (in_rdy !== 1'b0) begin bad++; $display("FAIL rel_in_rdy_low: got %b required 0", in_rdy); end
    step();
    total++; if (in_rdy !== 1'b1 || out_vld !== 1'b0) begin bad++; $display("FAIL rel_in_rdy_high: in_rdy=%b out_vld=%b required 1/0", in_rdy, out_vld); end
    step();
    total++; if (out_vld !== 1'b1 || out_dat !== 32'h11 || occ !== 2'd1) begin bad++; $display("FAIL first_beat: vld=%b dat=%h occ=%0d required 1/11/1", out_vld, out_dat, occ); end
    in_vld = 1'b0; out_rdy = 1'b1;
    step();
    total++; if (out_vld !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL first_drain: vld=%b occ=%0d required 0/0", out_vld, occ); end
  endtask

  task automatic test_stream();
    int n0;
    n0 = nout;
    out_rdy = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      in_vld = 1'b1; in_dat = W'(i);
      step();
      total++;
      if (out_vld !== 1'b1 || out_dat !== W'(i) || occ !== 2'd1 || in_rdy !== 1'b1) begin
        bad++;
        $display("FAIL stream_beat: vld=%b dat=%h occ=%0d rdy=%b required 1/%h/1/1", out_vld, out_dat, occ, in_rdy, W'(i));
      end
    end
    in_vld = 1'b0;
    step();
    total++; if (nout - n0 !== 16 || sb.size() !== 0 || occ !== 2'd0) begin bad++; $display("FAIL stream_count: out=%0d left=%0d occ=%0d required 16/0/0", nout - n0, sb.size(), occ); end
  endtask

  task automatic test_stall();
    out_rdy = 1'b0; in_vld = 1'b1; in_dat = 32'hA0;
    step();
    total++; if (occ !== 2'd1 || in_rdy !== 1'b1 || out_dat !== 32'hA0) begin bad++; $display("FAIL stall_one: occ=%0d rdy=%b dat=%h required 1/1/a0", occ, in_rdy, out_dat); end
    in_dat = 32'hA1;
    step();
    total++; if (occ !== 2'd2 || in_rdy !== 1'b0 || out_dat !== 32'hA0) begin bad++; $display("FAIL stall_two: occ=%0d rdy=%b dat=%h required 2/0/a0", occ, in_rdy, out_dat); end
    in_dat = 32'hA2;
    repeat (3) step();
    total++; if (occ !== 2'd2 || out_vld !== 1'b1 || out_dat !== 32'hA0) begin bad++; $display("FAIL stall_hold_two: occ=%0d vld=%b dat=%h required 2/1/a0", occ, out_vld, out_dat); end
    in_vld = 1'b0; out_rdy = 1'b1;
    step();
    total++; if (out_dat !== 32'hA1 || occ !== 2'd1 || in_rdy !== 1'b1) begin bad++; $display("FAIL stall_release: dat=%h occ=%0d rdy=%b required a1/1/1", out_dat, occ, in_rdy); end
    step();
    total++; if (out_vld !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL stall_empty: vld=%b occ=%0d required 0/0", out_vld, occ); end
  endtask

  task automatic test_random();
    int n0;
    int guard;
    n0 = nout;
    for (int i = 0; i < 10000; i++) begin
      in_vld  = 1'($urandom_range(0, 1));
      out_rdy = 1'($urandom_range(0, 1));
      in_dat  = W'($urandom);
      step();
      total++;
      if (int'(occ) !== sb.size()) begin
        bad++;
        $display("FAIL rand_occ: occ=%0d required %0d at iter %0d", occ, sb.size(), i);
      end
    end
    in_vld = 1'b0; out_rdy = 1'b1;
    guard = 0;
    while (out_vld === 1'b1 && guard < 4) begin
      step();
      guard++;
    end
    total++; if (out_vld !== 1'b0 || sb.size() !== 0) begin bad++; $display("FAIL rand_drain: vld=%b left=%0d required 0/0", out_vld, sb.size()); end
    total++; if (nout - n0 < 1000) begin bad++; $display("FAIL rand_traffic: beats=%0d required >= 1000", nout - n0); end
  endtask

  task automatic test_clear();
    int n0;
    out_rdy = 1'b0; in_vld = 1'b1; in_dat = 32'hB0;
    step();
    in_dat = 32'hB1;
    step();
    total++; if (occ !== 2'd2) begin bad++; $display("FAIL clr_fill: occ=%0d required 2", occ); end
    n0 = nout;
    clr = 1'b1; in_dat = 32'hB2;
    step();
    clr = 1'b0; in_vld = 1'b0;
    total++; if (out_vld !== 1'b0 || occ !== 2'd0 || in_rdy !== 1'b1) begin bad++; $display("FAIL clr_flush: vld=%b occ=%0d rdy=%b required 0/0/1", out_vld, occ, in_rdy); end
    clr = 1'b1; in_vld = 1'b1; in_dat = 32'hB3;
    step();
    clr = 1'b0; in_vld = 1'b0;
    total++; if (out_vld !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL clr_acc_drop: vld=%b occ=%0d required 0/0", out_vld, occ); end
    out_rdy = 1'b1;
    repeat (3) step();
    total++; if (out_vld !== 1'b0 || nout !== n0) begin bad++; $display("FAIL clr_no_output: vld=%b beats=%0d required 0/0", out_vld, nout - n0); end
  endtask

  task automatic test_async_reset();
    out_rdy = 1'b0; in_vld = 1'b1; in_dat = 32'hC0;
    step();
    in_dat = 32'hC1;
    step();
    in_vld = 1'b0;
    total++; if (occ !== 2'd2) begin bad++; $display("FAIL arst_fill: occ=%0d required 2", occ); end
    #2;
    rst = 1'b0;
    #1;
    total++; if (out_vld !== 1'b0 || occ !== 2'd0 || out_dat !== INI || in_rdy !== 1'b0) begin bad++; $display("FAIL arst_mid: vld=%b occ=%0d dat=%h rdy=%b required 0/0/%h/0", out_vld, occ, out_dat, in_rdy, INI); end
    step();
    rst = 1'b1; out_rdy = 1'b1;
    repeat (3) step();
    total++; if (in_rdy !== 1'b1 || out_vld !== 1'b0 || occ !== 2'd0) begin bad++; $display("FAIL arst_after: rdy=%b vld=%b occ=%0d required 1/0/0", in_rdy, out_vld, occ); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_random();
    test_clear();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
